// File: rtl/icache_if.sv
// icache_if: groups the instruction-cache signals into one bundle.
//   Datapath side : imemREN, imemaddr, flush -> cache ; ihit, imemload <- cache
//   Memory side   : iREN, iaddr <- cache ; iwait, iload -> cache
//   Statistics    : hit_count, miss_count <- cache
// The cache connects through the slave modport. Whatever drives the
// requests and models memory (datapath plus memory control, or a bench)
// connects through the master modport.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped instruction cache with one-word lines.
//   A hit is answered in the same cycle (ihit/imemload are combinational).
//   A miss latches the address and runs a one-word fill on the memory port.
//   Ports:
//     CLK   - rising-edge clock
//     nRST  - asynchronous active-low reset
//     bus   - icache_if.slave (datapath request/response, memory fill port,
//             hit/miss counters)
//
// state | meaning
// IDLE  | serve hits; a miss latches miss_addr and moves to FETCH
// FETCH | iREN=1 at miss_addr until iwait=0, then write the line and return
module icache #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4
) (
  input  logic CLK,
  input  logic nRST,
  icache_if.slave bus
);

  localparam int TAG_W = 32 - IDX_W - 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      miss_addr_q, miss_addr_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  logic [31:0]      data_q [SETS];
  logic [31:0]      data_d [SETS];
  logic [31:0]      hit_count_q, hit_count_d;
  logic [31:0]      miss_count_q, miss_count_d;

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             hit;

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr_q[IDX_W+1:2];
  assign fill_tag = miss_addr_q[31:IDX_W+2];

  // Hits are only reported in IDLE so a line being refilled is never served.
  assign hit = bus.imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag)
             & (state_q == IDLE);

  assign bus.ihit       = hit;
  assign bus.imemload   = hit ? data_q[req_idx] : 32'h0;
  assign bus.iREN       = (state_q == FETCH);
  assign bus.iaddr      = miss_addr_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    hit_count_d  = hit_count_q + {31'b0, hit};
    miss_count_d = miss_count_q;

    case (state_q)
      IDLE: begin
        if (bus.imemREN && !hit && !bus.flush) begin
          miss_addr_d  = bus.imemaddr;
          miss_count_d = miss_count_q + 32'd1;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        // Flush wins over a fill completing in the same cycle.
        if (bus.flush) begin
          state_d = IDLE;
        end else if (!bus.iwait) begin
          valid_d[fill_idx] = 1'b1;
          tag_d[fill_idx]   = fill_tag;
          data_d[fill_idx]  = bus.iload;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  localparam int SETS = 16;

  logic clk;
  logic nrst;

  icache_if bus ();

  icache #(.SETS(SETS), .IDX_W(4)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] load;
    logic        iren;
    logic [31:0] iaddr;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Reference model: the cache as a table of which word address each set holds.
  bit          m_valid [SETS];
  logic [29:0] m_word  [SETS];
  logic [31:0] m_data  [SETS];
  bit          m_busy;
  logic [31:0] m_addr;
  logic [31:0] m_hc, m_mc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h40) return 32'h2108_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 1'b0;
      m_word[i]  = '0;
      m_data[i]  = '0;
    end
    m_busy = 1'b0;
    m_addr = '0;
    m_hc   = '0;
    m_mc   = '0;
  endtask

  // One cycle of stimulus: drive inputs, queue the expected response, advance the model.
  task automatic cyc(input logic req, input logic [31:0] addr, input logic fl, input logic iw);
    exp_t e;
    int   idx;
    logic h;
    @(posedge clk);
    #1;
    bus.imemREN  = req;
    bus.imemaddr = addr;
    bus.flush    = fl;
    bus.iwait    = iw;
    bus.iload    = m_busy ? mem_data(m_addr) : $urandom;

    idx = int'((addr >> 2) % 32'd16);
    h   = req && !m_busy && m_valid[idx] && (m_word[idx] == addr[31:2]);

    e.hit   = h;
    e.load  = h ? m_data[idx] : 32'h0;
    e.iren  = m_busy;
    e.iaddr = m_addr;
    e.hc    = m_hc;
    e.mc    = m_mc;
    sbq.push_back(e);

    if (h) m_hc = m_hc + 32'd1;
    if (fl) begin
      for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (!iw) begin
        idx          = int'((m_addr >> 2) % 32'd16);
        m_valid[idx] = 1'b1;
        m_word[idx]  = m_addr[31:2];
        m_data[idx]  = mem_data(m_addr);
        m_busy       = 1'b0;
      end
    end else if (req && !h) begin
      m_busy = 1'b1;
      m_addr = addr;
      m_mc   = m_mc + 32'd1;
    end
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    nrst = 1'b0;
    bus.imemREN = 1'b0;
    bus.flush   = 1'b0;
    bus.iwait   = 1'b1;
    #1;
    chk("rst_iren", {31'b0, bus.iREN}, 32'h0);
    chk("rst_ihit", {31'b0, bus.ihit}, 32'h0);
    chk("rst_iaddr", bus.iaddr, 32'h0);
    chk("rst_hit_count", bus.hit_count, 32'h0);
    chk("rst_miss_count", bus.miss_count, 32'h0);
    sbq.delete();
    model_reset();
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  // Monitor: every sampled cycle is compared against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("ihit", {31'b0, bus.ihit}, {31'b0, e.hit});
      chk("imemload", bus.imemload, e.load);
      chk("iren", {31'b0, bus.iREN}, {31'b0, e.iren});
      if (e.iren) chk("iaddr", bus.iaddr, e.iaddr);
      chk("hit_count", bus.hit_count, e.hc);
      chk("miss_count", bus.miss_count, e.mc);
    end
  end

  initial begin
    logic [31:0] a;
    nrst         = 1'b1;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.flush    = 1'b0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    model_reset();
    do_reset();

    // Cold miss with two wait cycles, then hits.
    cyc(1, 32'h40, 0, 1);
    cyc(1, 32'h40, 0, 1);
    cyc(1, 32'h40, 0, 1);
    cyc(1, 32'h40, 0, 0);
    cyc(1, 32'h40, 0, 0);
    cyc(1, 32'h40, 0, 1);

    // Conflict in set 0.
    cyc(1, 32'h80, 0, 1);
    cyc(1, 32'h80, 0, 0);
    cyc(1, 32'h80, 0, 0);
    cyc(1, 32'h40, 0, 1);
    cyc(1, 32'h40, 0, 0);
    cyc(1, 32'h40, 0, 0);

    // Address change during a fill.
    cyc(1, 32'h44, 0, 1);
    cyc(1, 32'h48, 0, 1);
    cyc(1, 32'h48, 0, 0);
    cyc(1, 32'h48, 0, 1);
    cyc(1, 32'h48, 0, 0);
    cyc(1, 32'h44, 0, 1);
    cyc(1, 32'h48, 0, 1);

    // Flush beats a completing fill.
    cyc(0, 32'h0, 1, 1);
    cyc(1, 32'h44, 0, 1);
    cyc(1, 32'h44, 1, 0);
    cyc(1, 32'h44, 0, 1);
    cyc(1, 32'h44, 0, 0);
    cyc(1, 32'h44, 0, 0);

    // Idle request, then flush during a hit.
    cyc(1, 32'h40, 0, 1);
    cyc(1, 32'h40, 0, 0);
    cyc(1, 32'h40, 0, 0);
    cyc(0, 32'h40, 0, 0);
    cyc(0, 32'h40, 0, 0);
    cyc(1, 32'h40, 1, 0);
    cyc(1, 32'h40, 0, 1);
    cyc(1, 32'h40, 0, 0);
    cyc(1, 32'h40, 0, 0);

    // Asynchronous reset in the middle of a fill.
    cyc(1, 32'h80, 0, 1);
    cyc(1, 32'h80, 0, 1);
    do_reset();
    cyc(1, 32'h40, 0, 1);
    cyc(1, 32'h40, 0, 0);
    cyc(1, 32'h40, 0, 0);

    // Random traffic over 4 tags x 16 sets.
    for (int n = 0; n < 2000; n++) begin
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
      cyc(($urandom_range(0, 9) < 8), a, ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 1) == 1));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
